// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits one 5-bit code pulse {valid, col, row} per debounced press.
module keypad_scanner #(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [4:0] value
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DS_C = CW'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    HOLD
  } state_t;

  state_t        state, state_n;
  logic [1:0]    col, col_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    key, key_n;
  logic [DW-1:0] div;
  logic [3:0]    rows_m, rows_s;
  logic          sample;
  logic          any_low;
  logic [1:0]    lo_row;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
      div    <= '0;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
      div    <= sample ? '0 : div + DW'(1);
    end
  end

  assign sample  = (div == DIV_LAST);
  assign any_low = ~&rows_s;
  assign cnt_inc = cnt + CW'(1);

  // lowest-numbered low row wins
  always_comb begin
    lo_row = 2'd0;
    priority case (1'b1)
      !rows_s[0]: lo_row = 2'd0;
      !rows_s[1]: lo_row = 2'd1;
      !rows_s[2]: lo_row = 2'd2;
      !rows_s[3]: lo_row = 2'd3;
      default:    lo_row = 2'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      col   <= 2'd0;
      cnt   <= '0;
      key   <= 4'd0;
    end else begin
      state <= state_n;
      col   <= col_n;
      cnt   <= cnt_n;
      key   <= key_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    cnt_n   = cnt;
    key_n   = key;
    unique case (state)
      SCAN: begin
        if (sample) begin
          if (any_low) begin
            key_n   = {col, lo_row};
            cnt_n   = CW'(1);
            state_n = (DEBOUNCE_SAMPLES == 1) ? EMIT : DEBOUNCE;
          end else begin
            col_n = col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (any_low && lo_row == key[1:0]) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DS_C) state_n = EMIT;
          end else begin
            cnt_n   = '0;
            col_n   = col + 2'd1;
            state_n = SCAN;
          end
        end
      end
      EMIT: begin
        cnt_n   = '0;
        state_n = HOLD;
      end
      HOLD: begin
        // only the latched row matters while waiting for release
        if (sample) begin
          if (rows_s[key[1:0]]) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DS_C) begin
              cnt_n   = '0;
              col_n   = col + 2'd1;
              state_n = SCAN;
            end
          end else begin
            cnt_n = '0;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  assign columns = ~(4'b0001 << col);
  assign value   = (state == EMIT) ? {1'b1, key} : 5'b00000;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad and debounces key presses.
- Emits each debounced press as a one-cycle 5-bit key code on `value`; this is the producer end of the key-code interface the calculator core consumes.
- A held key produces exactly one code pulse; the key must be released, and the release debounced, before any new code is produced.
- Sits between the board keypad pins and the calculator control logic.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven before its rows are sampled (1 ms at 50 MHz); must be >= 2.
- DEBOUNCE_SAMPLES, 4: consecutive matching samples needed to accept a press, and likewise a release; must be >= 1.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- rows  input  4  keypad row lines; pulled up externally; a pressed key on the driven column reads 0.
- columns  output  4  column drive, active-low one-hot; the driven column is 0 and the others are 1.
- value  output  5  key code. Bit 4 is the valid flag; bits [3:2] are the column index; bits [1:0] are the row index. It is 5'b00000 when idle.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: state=SCAN, col=0, columns=4'b1110, value=5'b00000, divider=0, stable counter=0, latched key=0.
- Input synchronisation: rows pass through a 2-flop synchroniser (rows_s). All decisions use rows_s.
- Sample pulse:
  - The divider counts 0..SCAN_DIV-1 and then wraps.
  - A sample pulse occurs on the cycle divider==SCAN_DIV-1.
  - The divider runs in every state; it is not reset on state changes.
- Column drive: columns = ~(4'b0001 << col). col changes only on a sample pulse in SCAN, or on the exit to SCAN described below. It wraps 3 -> 0.
- Row selection: if several rows read 0, the lowest row index wins.
- State SCAN:
  - On a sample pulse with any rows_s bit 0: latch key={col,row}, set stable counter=1, go to DEBOUNCE. col is held.
  - On a sample pulse with all rows 1: col <= col+1.
  - If DEBOUNCE_SAMPLES==1, the transition goes directly to EMIT.
- State DEBOUNCE (col held):
  - On a sample pulse where the lowest low row equals the latched row: increment the counter. When it reaches DEBOUNCE_SAMPLES, go to EMIT.
  - On a sample pulse with a mismatch or no row low: counter=0, col <= col+1, go to SCAN.
- State EMIT (one cycle):
  - value = {1'b1, key} for exactly this clock. The registered output is high in the cycle after the qualifying sample.
  - Next state is HOLD with counter=0.
- State HOLD (col held):
  - Only the latched row bit is examined; other keys are ignored.
  - On a sample pulse with rows_s[row]==1: increment the counter. At DEBOUNCE_SAMPLES: counter=0, col <= col+1, go to SCAN.
  - On a sample pulse with rows_s[row]==0: counter=0.
- value is 5'b00000 in every state except EMIT.
- Code map:
  - col0 rows0..3 -> 1,4,7,0.
  - col1 -> 2,5,8,F.
  - col2 -> 3,6,9,E.
  - col3 -> A,B,C,D.
  - Example: key 1 -> 5'b10000; key D -> 5'b11111.
- Press latency: from a stable press to the value pulse is at most 4*SCAN_DIV + DEBOUNCE_SAMPLES*SCAN_DIV + 3 cycles.
- Reset mid-operation:
  - All state returns to the reset values immediately; any pending pulse is cancelled.
  - A key still held after reset is rescanned and emits one new code after debounce.
- Simultaneous keys in different columns: the first column scanned after col wins.

Test Plan (SCAN_DIV=4, DEBOUNCE_SAMPLES=3):
- Reset only, no keys -> columns cycle 1110, 1101, 1011, 0111 with each pattern held 4 clocks; value stays 0.
- Hold the col0/row0 key for 200 clocks -> value=5'b10000 for exactly 1 clock, no repeat; after release plus 3 release samples, scanning resumes.
- Press col3/row3 (D) -> exactly one value=5'b11111 pulse; press col1/row3 (F) -> exactly one 5'b10111 pulse.
- Bounce: row low for 2 samples, high for 1, repeated 10 times -> value never nonzero; then hold it steady -> one pulse.
- Rows 1 and 2 low together on col2 -> value=5'b11001 (key 6); releasing row 2 only while row 1 is held -> no new pulse.
- Assert reset during HOLD with the key still pressed -> value=0 and columns=1110 in the same cycle; after reset release, exactly one new pulse for the held key.
